// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU fetches and LSU accesses.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise the LSU always wins.
//
// state | meaning
// IDLE  | no transaction; grants and latches the winning request
// ISSUE | arb_mem_valid asserted with latched fields until mem_arb_ready
// WAIT  | accepted by memory; waiting for mem_arb_valid or watchdog expiry
// RESP  | one-cycle response pulse to the owner; requests not sampled
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 16
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              ifu_arb_valid,
  input  logic [ADDR_W-1:0] ifu_arb_addr,
  output logic              arb_ifu_valid,
  output logic [31:0]       arb_ifu_data,
  input  logic              lsu_arb_valid,
  input  logic [ADDR_W-1:0] lsu_arb_addr,
  input  logic [DATA_W-1:0] lsu_arb_data,
  input  logic              lsu_arb_dir,
  input  logic [3:0]        lsu_arb_width,
  output logic              arb_lsu_ready,
  output logic              arb_lsu_valid,
  output logic [DATA_W-1:0] arb_lsu_data,
  output logic              arb_mem_valid,
  output logic [ADDR_W-1:0] arb_mem_addr,
  output logic [DATA_W-1:0] arb_mem_data,
  output logic              arb_mem_dir,
  output logic [3:0]        arb_mem_width,
  input  logic              mem_arb_ready,
  input  logic              mem_arb_valid,
  input  logic [DATA_W-1:0] mem_arb_data,
  output logic              arb_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam bit                  WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0] WD_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic                owner_lsu;
  logic [TO_CNT_W-1:0] wd_cnt;
  logic                req_any;
  logic                grant_lsu;
  logic                rsp_fire;
  logic                rsp_to;
  logic [DATA_W-1:0]   rsp_val;

  assign req_any = ifu_arb_valid | lsu_arb_valid;

`ifdef MEM_ARB_RR_EN
  logic last_lsu;

  // on conflict, whoever was not granted last time wins
  assign grant_lsu = lsu_arb_valid & (~ifu_arb_valid | ~last_lsu);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      last_lsu <= 1'b0;
    end else if (state == IDLE && req_any) begin
      last_lsu <= grant_lsu;
    end
  end
`else
  assign grant_lsu = lsu_arb_valid;
`endif

  // response completes either from memory or from watchdog expiry (data forced to 0)
  always_comb begin
    rsp_fire = 1'b0;
    rsp_to   = 1'b0;
    rsp_val  = mem_arb_data;
    if (state == ISSUE) begin
      rsp_fire = mem_arb_ready & mem_arb_valid;
    end else if (state == WAIT) begin
      if (mem_arb_valid) begin
        rsp_fire = 1'b1;
      end else if (WD_EN && wd_cnt == WD_LAST) begin
        rsp_fire = 1'b1;
        rsp_to   = 1'b1;
        rsp_val  = '0;
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state         <= IDLE;
      owner_lsu     <= 1'b0;
      wd_cnt        <= '0;
      arb_lsu_ready <= 1'b1;
      arb_ifu_valid <= 1'b0;
      arb_ifu_data  <= '0;
      arb_lsu_valid <= 1'b0;
      arb_lsu_data  <= '0;
      arb_mem_valid <= 1'b0;
      arb_mem_addr  <= '0;
      arb_mem_data  <= '0;
      arb_mem_dir   <= 1'b0;
      arb_mem_width <= '0;
      arb_timeout   <= 1'b0;
    end else begin
      arb_ifu_valid <= 1'b0;
      arb_lsu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state         <= ISSUE;
            owner_lsu     <= grant_lsu;
            arb_lsu_ready <= 1'b0;
            arb_mem_valid <= 1'b1;
            if (grant_lsu) begin
              arb_mem_addr  <= lsu_arb_addr;
              arb_mem_data  <= lsu_arb_data;
              arb_mem_dir   <= lsu_arb_dir;
              arb_mem_width <= lsu_arb_width;
            end else begin
              arb_mem_addr  <= ifu_arb_addr;
              arb_mem_data  <= '0;
              arb_mem_dir   <= 1'b0;
              arb_mem_width <= 4'd4;
            end
          end
        end
        ISSUE: begin
          if (mem_arb_ready) begin
            arb_mem_valid <= 1'b0;
            if (!rsp_fire) begin
              state  <= WAIT;
              wd_cnt <= '0;
            end
          end
        end
        WAIT: begin
          if (!rsp_fire) wd_cnt <= wd_cnt + 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          arb_lsu_ready <= 1'b1;
          arb_ifu_data  <= '0;
          arb_lsu_data  <= '0;
        end
        default: state <= IDLE;
      endcase

      if (rsp_fire) begin
        state <= RESP;
        if (rsp_to) arb_timeout <= 1'b1;
        if (owner_lsu) begin
          arb_lsu_valid <= 1'b1;
          arb_lsu_data  <= arb_mem_dir ? '0 : rsp_val;
        end else begin
          arb_ifu_valid <= 1'b1;
          arb_ifu_data  <= rsp_val[31:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences for
// priority/hold/watchdog/reset, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              core_clk = 1'b0;
  logic              core_rst_n;
  logic              ifu_arb_valid;
  logic [ADDR_W-1:0] ifu_arb_addr;
  logic              arb_ifu_valid;
  logic [31:0]       arb_ifu_data;
  logic              lsu_arb_valid;
  logic [ADDR_W-1:0] lsu_arb_addr;
  logic [DATA_W-1:0] lsu_arb_data;
  logic              lsu_arb_dir;
  logic [3:0]        lsu_arb_width;
  logic              arb_lsu_ready;
  logic              arb_lsu_valid;
  logic [DATA_W-1:0] arb_lsu_data;
  logic              arb_mem_valid;
  logic [ADDR_W-1:0] arb_mem_addr;
  logic [DATA_W-1:0] arb_mem_data;
  logic              arb_mem_dir;
  logic [3:0]        arb_mem_width;
  logic              mem_arb_ready;
  logic              mem_arb_valid;
  logic [DATA_W-1:0] mem_arb_data;
  logic              arb_timeout;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8), .TO_CNT_W(16)
  ) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .ifu_arb_valid(ifu_arb_valid), .ifu_arb_addr(ifu_arb_addr),
    .arb_ifu_valid(arb_ifu_valid), .arb_ifu_data(arb_ifu_data),
    .lsu_arb_valid(lsu_arb_valid), .lsu_arb_addr(lsu_arb_addr),
    .lsu_arb_data(lsu_arb_data), .lsu_arb_dir(lsu_arb_dir), .lsu_arb_width(lsu_arb_width),
    .arb_lsu_ready(arb_lsu_ready), .arb_lsu_valid(arb_lsu_valid), .arb_lsu_data(arb_lsu_data),
    .arb_mem_valid(arb_mem_valid), .arb_mem_addr(arb_mem_addr), .arb_mem_data(arb_mem_data),
    .arb_mem_dir(arb_mem_dir), .arb_mem_width(arb_mem_width),
    .mem_arb_ready(mem_arb_ready), .mem_arb_valid(mem_arb_valid), .mem_arb_data(mem_arb_data),
    .arb_timeout(arb_timeout)
  );

  always #5 core_clk = ~core_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit          lsu;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          dir;
    logic [3:0]  width;
    int          stall;
    int          delay;
    logic [63:0] rdata;
    int          exp_lat;
    logic [63:0] exp_rsp;
    bit          exp_dir;
    logic [3:0]  exp_width;
    logic [63:0] exp_mdata;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_arb_valid = 1'b0; ifu_arb_addr = '0;
    lsu_arb_valid = 1'b0; lsu_arb_addr = '0; lsu_arb_data = '0;
    lsu_arb_dir = 1'b0; lsu_arb_width = '0;
    mem_arb_ready = 1'b0; mem_arb_valid = 1'b0; mem_arb_data = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    core_rst_n = 1'b0;
    tick();
    tick();
    core_rst_n = 1'b1;
    tick();
  endtask

  // one request with a scripted memory: stall = ready-low cycles, delay = WAIT cycles (0 = same cycle)
  task automatic run_txn(input vec_t v, input string nm);
    int iss_n  = 0;
    int wait_n = 0;
    bit acc    = 1'b0;
    bit done   = 1'b0;
    chk({nm, "_ready"}, 64'(arb_lsu_ready), 64'd1);
    ifu_arb_addr  = v.addr;
    lsu_arb_addr  = v.addr;
    lsu_arb_data  = v.wdata;
    lsu_arb_dir   = v.dir;
    lsu_arb_width = v.width;
    if (v.lsu) lsu_arb_valid = 1'b1;
    else       ifu_arb_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (arb_lsu_valid || arb_ifu_valid) begin
        chk({nm, "_owner"}, 64'({arb_lsu_valid, arb_ifu_valid}), v.lsu ? 64'd2 : 64'd1);
        chk({nm, "_lat"}, 64'(c), 64'(v.exp_lat));
        chk({nm, "_data"}, v.lsu ? arb_lsu_data : {32'h0, arb_ifu_data}, v.exp_rsp);
        lsu_arb_valid = 1'b0;
        ifu_arb_valid = 1'b0;
        done = 1'b1;
      end
      mem_arb_ready = 1'b0;
      mem_arb_valid = 1'b0;
      if (arb_mem_valid) begin
        chk({nm, "_addr"}, arb_mem_addr, v.addr);
        chk({nm, "_dirw"}, 64'({arb_mem_dir, arb_mem_width}), 64'({v.exp_dir, v.exp_width}));
        chk({nm, "_mdata"}, arb_mem_data, v.exp_mdata);
        if (iss_n >= v.stall) begin
          mem_arb_ready = 1'b1;
          if (v.delay == 0) begin
            mem_arb_valid = 1'b1;
            mem_arb_data  = v.rdata;
          end else begin
            acc = 1'b1;
          end
        end
        iss_n++;
      end else if (acc) begin
        wait_n++;
        if (wait_n == v.delay) begin
          mem_arb_valid = 1'b1;
          mem_arb_data  = v.rdata;
          acc = 1'b0;
        end
      end
      tick();
    end
    if (!done) chk({nm, "_no_response"}, 64'(done), 64'd1);
    chk({nm, "_pulse_end"}, 64'({arb_lsu_valid, arb_ifu_valid}), 64'd0);
    chk({nm, "_idle"}, 64'(arb_lsu_ready), 64'd1);
  endtask

  int       p, n, pulses, issues, lsu_left;
  logic [2:0] ord;

  // randomized-run model state
  bit          ip, lp, prev_iv, prev_lv, prev_mv, txn, t_lsu, acc, due, last_lsu, g_lsu, stop;
  logic [63:0] i_addr, l_addr, l_data, t_rd, t_exp, t_addr, t_mdata;
  bit          l_dir, t_dir;
  logic [3:0]  l_w, t_w;
  int          st, dl, iss_n, wait_n;

  initial begin
    vt[0] = '{1'b0, 64'h8000_0000, 64'h0, 1'b0, 4'd0, 0, 0, 64'h0000_0000_0000_0413,
              2, 64'h413, 1'b0, 4'd4, 64'h0};
    vt[1] = '{1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 1'b1, 4'd4, 2, 3, 64'h1234_5678,
              7, 64'h0, 1'b1, 4'd4, 64'hDEAD_BEEF};
    vt[2] = '{1'b1, 64'h1000_0008, 64'h0, 1'b0, 4'd8, 0, 1, 64'hFEDC_BA98_7654_3210,
              3, 64'hFEDC_BA98_7654_3210, 1'b0, 4'd8, 64'h0};
    vt[3] = '{1'b0, 64'h8000_0004, 64'h1111_2222_3333_4444, 1'b1, 4'd8, 1, 2,
              64'hAAAA_BBBB_0000_0073, 5, 64'h73, 1'b0, 4'd4, 64'h0};
    vt[4] = '{1'b1, 64'h3, 64'h0, 1'b0, 4'd1, 3, 0, 64'hFF, 5, 64'hFF, 1'b0, 4'd1, 64'h0};
    vt[5] = '{1'b1, 64'h20, 64'hBEEF, 1'b1, 4'd2, 0, 0, 64'h55, 2, 64'h0, 1'b1, 4'd2, 64'hBEEF};

    // reset values
    clear_inputs();
    core_rst_n = 1'b0;
    tick();
    chk("rst_ready", 64'(arb_lsu_ready), 64'd1);
    chk("rst_valids", 64'({arb_mem_valid, arb_lsu_valid, arb_ifu_valid, arb_timeout}), 64'd0);
    chk("rst_fields", arb_mem_addr | arb_mem_data | 64'(arb_mem_width) | 64'(arb_mem_dir), 64'd0);
    core_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // simultaneous requests: LSU re-requests once, IFU once
    reset_dut();
    ifu_arb_addr = 64'h8000_0100; lsu_arb_addr = 64'h9000_0000; lsu_arb_width = 4'd8;
    ifu_arb_valid = 1'b1; lsu_arb_valid = 1'b1;
    lsu_left = 2; n = 0; ord = '0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (arb_lsu_valid && n < 3) begin
        ord[n] = 1'b1; n++; lsu_left--;
        if (lsu_left == 0) lsu_arb_valid = 1'b0;
      end
      if (arb_ifu_valid && n < 3) begin
        ord[n] = 1'b0; n++; ifu_arb_valid = 1'b0;
      end
      mem_arb_ready = arb_mem_valid; mem_arb_valid = arb_mem_valid; mem_arb_data = 64'h13;
      tick();
    end
    ifu_arb_valid = 1'b0; lsu_arb_valid = 1'b0;
    mem_arb_ready = 1'b0; mem_arb_valid = 1'b0;
    chk("prio_count", 64'(n), 64'd3);
`ifdef MEM_ARB_RR_EN
    chk("prio_order_rr", 64'(ord), 64'b101);
`else
    chk("prio_order_fixed", 64'(ord), 64'b011);
`endif
    tick();

    // IFU held 10 cycles past its first pulse
    ifu_arb_addr = 64'h8000_0200; ifu_arb_valid = 1'b1;
    p = -1; pulses = 0; issues = 0;
    for (int c = 0; c < 60; c++) begin
      if (arb_ifu_valid) begin
        if (p < 0) p = c;
        else pulses++;
        chk("hold_no_issue_in_resp", 64'(arb_mem_valid), 64'd0);
      end
      if (p >= 0 && c > p && arb_mem_valid) issues++;
      if (p >= 0 && c == p + 10) ifu_arb_valid = 1'b0;
      mem_arb_ready = arb_mem_valid; mem_arb_valid = arb_mem_valid; mem_arb_data = 64'h17;
      tick();
    end
    mem_arb_ready = 1'b0; mem_arb_valid = 1'b0;
    chk("hold_first_lat", 64'(p), 64'd2);
    chk("hold_pulses", 64'(pulses), 64'd3);
    chk("hold_issues", 64'(issues), 64'd3);

    // randomized traffic against a transaction-level model
    reset_dut();
    ip = 0; lp = 0; prev_iv = 0; prev_lv = 0; prev_mv = 0; txn = 0; t_lsu = 0;
    acc = 0; due = 0; last_lsu = 0; stop = 0; st = 0; dl = 0; iss_n = 0; wait_n = 0;
    i_addr = '0; l_addr = '0; l_data = '0; l_dir = 0; l_w = 4'd1;
    t_rd = '0; t_exp = '0; t_addr = '0; t_mdata = '0; t_dir = 0; t_w = '0;
    for (int c = 0; c < 1600; c++) begin
      stop = (c >= 1500);
      chk("rnd_pulse", 64'({arb_lsu_valid, arb_ifu_valid}),
          due ? (t_lsu ? 64'd2 : 64'd1) : 64'd0);
      if (due) begin
        chk("rnd_data", t_lsu ? arb_lsu_data : {32'h0, arb_ifu_data}, t_exp);
        if (t_lsu) lp = 0;
        else       ip = 0;
        txn = 0; due = 0;
      end
      if (arb_mem_valid && !prev_mv) begin
        chk("rnd_grant_pending", 64'(prev_lv | prev_iv), 64'd1);
        chk("rnd_overlap", 64'(txn), 64'd0);
`ifdef MEM_ARB_RR_EN
        if (prev_lv && prev_iv) g_lsu = !last_lsu;
        else                    g_lsu = prev_lv;
`else
        g_lsu = prev_lv;
`endif
        last_lsu = g_lsu;
        txn = 1; t_lsu = g_lsu;
        t_addr  = g_lsu ? l_addr : i_addr;
        t_dir   = g_lsu ? l_dir : 1'b0;
        t_w     = g_lsu ? l_w : 4'd4;
        t_mdata = g_lsu ? l_data : 64'h0;
        st = $urandom_range(0, 3); dl = $urandom_range(0, 4);
        t_rd = {$urandom, $urandom}; iss_n = 0; wait_n = 0;
        t_exp = g_lsu ? (l_dir ? 64'h0 : t_rd) : {32'h0, t_rd[31:0]};
      end
      if (arb_mem_valid) begin
        chk("rnd_addr", arb_mem_addr, t_addr);
        chk("rnd_dirw", 64'({arb_mem_dir, arb_mem_width}), 64'({t_dir, t_w}));
        chk("rnd_mdata", arb_mem_data, t_mdata);
      end
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b0; mem_arb_data = {$urandom, $urandom};
      if (arb_mem_valid) begin
        if (iss_n >= st) begin
          mem_arb_ready = 1'b1;
          if (dl == 0) begin
            mem_arb_valid = 1'b1; mem_arb_data = t_rd; due = 1;
          end else begin
            acc = 1;
          end
        end
        iss_n++;
      end else if (acc) begin
        wait_n++;
        if (wait_n == dl) begin
          mem_arb_valid = 1'b1; mem_arb_data = t_rd; acc = 0; due = 1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_arb_valid = 1'b1;  // stray response while idle or responding
      end
      if (!stop && !ip && $urandom_range(0, 2) == 0) begin
        ip = 1; i_addr = {$urandom, $urandom};
      end
      if (!stop && !lp && $urandom_range(0, 2) == 0) begin
        lp = 1; l_addr = {$urandom, $urandom}; l_data = {$urandom, $urandom};
        l_dir = 1'($urandom_range(0, 1)); l_w = 4'(1 << $urandom_range(0, 3));
      end
      ifu_arb_valid = ip; ifu_arb_addr = i_addr;
      lsu_arb_valid = lp; lsu_arb_addr = l_addr; lsu_arb_data = l_data;
      lsu_arb_dir = l_dir; lsu_arb_width = l_w;
      prev_iv = ip; prev_lv = lp; prev_mv = arb_mem_valid;
      tick();
    end
    chk("rnd_drained", 64'({ip, lp, txn}), 64'd0);
    chk("rnd_no_timeout", 64'(arb_timeout), 64'd0);
    clear_inputs();
    tick();

    // watchdog: LSU read accepted, memory never answers
    lsu_arb_addr = 64'h40; lsu_arb_dir = 1'b0; lsu_arb_width = 4'd8; lsu_arb_valid = 1'b1;
    p = -1;
    for (int c = 0; c < 30 && p < 0; c++) begin
      if (c == 9) chk("wd_not_yet", 64'(arb_timeout), 64'd0);
      if (arb_lsu_valid) begin
        p = c;
        chk("wd_data", arb_lsu_data, 64'd0);
        chk("wd_flag", 64'(arb_timeout), 64'd1);
        lsu_arb_valid = 1'b0;
      end
      mem_arb_ready = arb_mem_valid; mem_arb_valid = 1'b0;
      tick();
    end
    mem_arb_ready = 1'b0;
    chk("wd_lat", 64'(p), 64'd10);
    chk("wd_sticky", 64'(arb_timeout), 64'd1);
    run_txn(vt[2], "wd_after");
    chk("wd_sticky_after", 64'(arb_timeout), 64'd1);

    // reset during WAIT, then a late response
    lsu_arb_addr = 64'h80; lsu_arb_dir = 1'b0; lsu_arb_width = 4'd8; lsu_arb_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mem_arb_ready = arb_mem_valid; mem_arb_valid = 1'b0;
      tick();
    end
    chk("rst_mid_busy", 64'(arb_lsu_ready), 64'd0);
    lsu_arb_valid = 1'b0; mem_arb_ready = 1'b0;
    core_rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(arb_lsu_ready), 64'd1);
    chk("rst_mid_valids", 64'({arb_mem_valid, arb_lsu_valid, arb_ifu_valid, arb_timeout}), 64'd0);
    chk("rst_mid_addr", arb_mem_addr, 64'd0);
    tick();
    core_rst_n = 1'b1;
    mem_arb_valid = 1'b1; mem_arb_data = 64'hBAD;
    tick();
    mem_arb_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rst_late_rsp", 64'({arb_lsu_valid, arb_ifu_valid, arb_mem_valid}), 64'd0);
      chk("rst_late_ready", 64'(arb_lsu_ready), 64'd1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
